regfile_wb_arbiter: RTL
=======================

# regfile_wb_arbiter

Write-back arbiter and scoreboard for the 32×32 register file. Two writers compete for the file's single write port: the ALU result path (port 0) and the load-return path (port 1). The block grants them round-robin and drives the registered write-port signals `regWrite`/`writeReg`/`writeData`. It also keeps a per-register busy scoreboard so the issue stage can detect RAW hazards on `rs`/`rt`.

## Interface
Parameters:
- `DATA_W`, 32, write data width
- `ADDR_W`, 5, register index width (32 registers)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `req_valid`  in  2  per-requester write request (bit 0 ALU, bit 1 load)
- `req_addr0`  in  ADDR_W  destination register, requester 0
- `req_data0`  in  DATA_W  write data, requester 0
- `req_addr1`  in  ADDR_W  destination register, requester 1
- `req_data1`  in  DATA_W  write data, requester 1
- `req_ready`  out  2  one-hot grant; handshake completes when `req_valid[i] & req_ready[i]`
- `iss_valid`  in  1  issue stage dispatches an instruction with a destination
- `iss_dst`  in  ADDR_W  destination register of the issued instruction
- `rs`  in  ADDR_W  source register 1 to check
- `rt`  in  ADDR_W  source register 2 to check
- `rs_busy`  out  1  `rs` has a pending write
- `rt_busy`  out  1  `rt` has a pending write
- `regWrite`  out  1  register-file write enable
- `writeReg`  out  ADDR_W  register-file write address
- `writeData`  out  DATA_W  register-file write data

## Operation
- Arbitration (combinational):
  - If exactly one `req_valid` bit is set, that requester is granted.
  - If both are set, the requester that was not granted last is granted.
  - `req_ready` is never asserted without the matching `req_valid`.
- Pointer `last_grant` (1 bit) updates only on a completed handshake. Reset value is 1, so requester 0 wins the first tie.
- Output stage: a handshake registers the winner's addr/data into `writeReg`/`writeData` and sets `regWrite`=1 for one cycle. With no handshake, `regWrite`=0 and addr/data hold their previous values.
- Writes to register 0 are accepted and consumed, but `regWrite` is forced to 0 for them. Register 0 is never busy.
- Scoreboard `busy[31:0]`:
  - `iss_valid` with `iss_dst`≠0 sets `busy[iss_dst]`.
  - A completed handshake for address A clears `busy[A]`.
  - If the set and the clear hit the same register in the same cycle, the set wins.
  - A handshake to a non-busy register is legal and leaves `busy` unchanged.
- `rs_busy = busy[rs]` and `rt_busy = busy[rt]`, combinational from registered state.

## Timing
- Reset values: `regWrite`=0, `writeReg`=0, `writeData`=0, `busy`=0, `last_grant`=1.
- `req_ready` and `rs_busy`/`rt_busy` are 0 in reset and are driven purely from the current inputs and state.
- Latency: handshake at edge N produces `regWrite`=1 during cycle N+1. The register file commits the value at edge N+2.
- The busy bit clears at edge N+1, so during cycle N+1 `rs_busy` already reads 0 while the file still holds the old value. With `WB_BYPASS_EN` off, the issue stage must hold one more cycle; with it on, the bypass covers that cycle (see Configuration).
- Throughput: one write per cycle. A requester that is not granted must keep `req_valid`/addr/data stable until it is granted.
- Starvation bound: a continuously valid requester is granted within 2 cycles.
- Asserting `rst` mid-operation clears all state immediately. In-flight writes and pending busy bits are dropped.

## Configuration
- Macro: `REGFILE_WB_BYPASS_EN`.
- Defined:
  - Adds outputs `rs_fwd`/`rt_fwd` (1 bit) and `fwd_data` (DATA_W).
  - When `regWrite` is 1 and `writeReg` equals `rs` (or `rt`), and that register is non-zero, the matching `_fwd` output is 1 and `fwd_data`=`writeData`.
  - The issue stage may then proceed in the same cycle.
- Undefined: these ports are absent and the logic compiles out. Everything else is unchanged.

## Structure
- Shared package `regfile_pkg`:
  - `DATA_W`, `ADDR_W`, `NUM_REGS`=32
  - typedef `reg_idx_t`
  - constant `ZERO_REG`=0
- One sub-module, `rr_arbiter2`: 2-way round-robin grant with `last_grant` pointer. The scoreboard and output stage stay in the top module.

## Test plan
- Reset, then `req_valid`=2'b01, addr 5, data 0xDEADBEEF → `req_ready`=01; next cycle `regWrite`=1, `writeReg`=5, `writeData`=0xDEADBEEF; the cycle after, `regWrite`=0.
- Both valid for 4 cycles (addr 1 and addr 2) → grants alternate 01, 10, 01, 10; `writeReg` sequence is 1, 2, 1, 2.
- `iss_valid` with dst 7, then `rs`=7 → `rs_busy`=1 until the cycle after a handshake to 7, then 0. In the same cycle, an `iss_valid` to 7 coinciding with a write to 7 leaves `busy[7]`=1.
- Write to register 0, data 0x1234 → handshake completes, `regWrite` stays 0. `iss_dst`=0 never sets `rs_busy` for `rs`=0.
- Assert `rst` while `busy[3]`=1 and a handshake is pending → all outputs return to reset values immediately, and `rs_busy` for register 3 reads 0.
- With `REGFILE_WB_BYPASS_EN`: write addr 9, data 0xA5A5A5A5, `rt`=9 in the `regWrite` cycle → `rt_fwd`=1, `fwd_data`=0xA5A5A5A5.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-back slice.
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  localparam reg_idx_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back request, scoreboard query and register-file write-port bundle.
// Optional bypass signals appear when REGFILE_WB_BYPASS_EN is defined.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
);

  logic [1:0]        req_valid;
  logic [ADDR_W-1:0] req_addr0;
  logic [DATA_W-1:0] req_data0;
  logic [ADDR_W-1:0] req_addr1;
  logic [DATA_W-1:0] req_data1;
  logic [1:0]        req_ready;
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_dst;
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic              rs_busy;
  logic              rt_busy;
  logic              regWrite;
  logic [ADDR_W-1:0] writeReg;
  logic [DATA_W-1:0] writeData;
`ifdef REGFILE_WB_BYPASS_EN
  logic              rs_fwd;
  logic              rt_fwd;
  logic [DATA_W-1:0] fwd_data;

  modport slave (
    input  req_valid, req_addr0, req_data0, req_addr1, req_data1,
           iss_valid, iss_dst, rs, rt,
    output req_ready, rs_busy, rt_busy, regWrite, writeReg, writeData,
           rs_fwd, rt_fwd, fwd_data
  );

  modport master (
    output req_valid, req_addr0, req_data0, req_addr1, req_data1,
           iss_valid, iss_dst, rs, rt,
    input  req_ready, rs_busy, rt_busy, regWrite, writeReg, writeData,
           rs_fwd, rt_fwd, fwd_data
  );
`else
  modport slave (
    input  req_valid, req_addr0, req_data0, req_addr1, req_data1,
           iss_valid, iss_dst, rs, rt,
    output req_ready, rs_busy, rt_busy, regWrite, writeReg, writeData
  );

  modport master (
    output req_valid, req_addr0, req_data0, req_addr1, req_data1,
           iss_valid, iss_dst, rs, rt,
    input  req_ready, rs_busy, rt_busy, regWrite, writeReg, writeData
  );
`endif

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer remembers the last winner so a
// tie goes to the other requester. Grant is combinational and held low in reset.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid_i,
  output logic [1:0] grant_o
);

  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    grant_o = 2'b00;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_grant_q ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
    if (rst) grant_o = 2'b00;
  end

  // Grant implies valid, so any grant bit is a completed handshake.
  assign last_grant_d = (|grant_o) ? grant_o[1] : last_grant_q;

  // NOTE: flops update with <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant_q <= 1'b1;
    else     last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter, registered register-file write port and busy scoreboard.
// Define REGFILE_WB_BYPASS_EN to add the rs_fwd/rt_fwd/fwd_data bypass outputs.
import regfile_pkg::*;

module regfile_wb_arbiter #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  bus
);

  localparam int NREG = 1 << ADDR_W;

  logic [1:0]        grant;
  logic              hs;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] write_reg_q, write_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic [NREG-1:0]   busy_q, busy_d;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid_i (bus.req_valid),
    .grant_o (grant)
  );

  assign bus.req_ready = grant;
  assign hs            = |grant;
  assign win_addr      = grant[1] ? bus.req_addr1 : bus.req_addr0;
  assign win_data      = grant[1] ? bus.req_data1 : bus.req_data0;

  // NOTE: every always_comb output is defaulted first so no latch is inferred.
  always_comb begin
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (hs) begin
      // Register 0 writes are consumed but never reach the file.
      reg_write_d  = (win_addr != ADDR_W'(ZERO_REG));
      write_reg_d  = win_addr;
      write_data_d = win_data;
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (hs) busy_d[win_addr] = 1'b0;
    // Applied after the clear so a same-cycle issue keeps the bit set.
    if (bus.iss_valid && (bus.iss_dst != ADDR_W'(ZERO_REG))) busy_d[bus.iss_dst] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // NOTE: the scoreboard is a flop vector, not a RAM, so it is reset with the rest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      busy_q       <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.regWrite  = reg_write_q;
  assign bus.writeReg  = write_reg_q;
  assign bus.writeData = write_data_q;
  assign bus.rs_busy   = busy_q[bus.rs];
  assign bus.rt_busy   = busy_q[bus.rt];

`ifdef REGFILE_WB_BYPASS_EN
  // Covers the cycle where busy has cleared but the file has not committed yet.
  assign bus.rs_fwd   = reg_write_q && (write_reg_q == bus.rs) && (bus.rs != ADDR_W'(ZERO_REG));
  assign bus.rt_fwd   = reg_write_q && (write_reg_q == bus.rt) && (bus.rt != ADDR_W'(ZERO_REG));
  assign bus.fwd_data = write_data_q;
`endif

endmodule
